// File: rtl/uart_rx.sv
// uart_rx: receiving end of the uart_tx serial link.
// Recovers 11-bit frames (start, 8 data bits MSB first, parity, stop)
// at CLKS_PER_BIT clocks per bit, sampling each bit at counter value
// SAMPLE_AT (mid-bit).
//
// Ports:
//   clk_3125       3.125 MHz system clock, rising edge
//   rst_n          synchronous active-low reset
//   rx             asynchronous serial line, idles high
//   parity_type    0 = even, 1 = odd; held stable for the whole frame
//   rx_msg         last received byte (first wire data bit in rx_msg[7])
//   rx_parity_err  parity mismatch for the frame in rx_msg
//   rx_frame_err   stop bit sampled low for the frame in rx_msg
//   rx_complete    one-cycle strobe when rx_msg and the flags update
module uart_rx #(
  parameter int CLKS_PER_BIT = 14,
  parameter int SAMPLE_AT    = 6
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_msg,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_complete
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_AT);
  localparam logic [IDX_W-1:0] IDX_FIRST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_nxt;

  logic              s1;
  logic              rx_s;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic              at_sample;
  logic              at_last;

  // Even parity: the parity bit equals the XOR of the data, so a clean
  // frame gives zero; odd parity inverts the received bit first.
  function automatic logic parity_mismatch(input logic p,
                                           input logic [DATA_W-1:0] d,
                                           input logic odd);
    return p ^ (^d) ^ odd;
  endfunction

  assign at_sample = (cnt == CNT_SAMPLE);
  assign at_last   = (cnt == CNT_LAST);

  always_ff @(posedge clk_3125) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      // A start bit that is high again at mid-bit is treated as noise.
      START:   if (at_sample && rx_s) state_nxt = IDLE;
               else if (at_last)      state_nxt = DATA;
      DATA:    if (at_last && idx == '0) state_nxt = PARITY;
      PARITY:  if (at_last) state_nxt = STOP;
      // Leave at mid-stop-bit so an immediately following start edge
      // is caught from IDLE.
      STOP:    if (at_sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input synchroniser, bit timing and frame capture
  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      s1            <= 1'b1;
      rx_s          <= 1'b1;
      cnt           <= '0;
      idx           <= IDX_FIRST;
      shift         <= '0;
      par           <= 1'b0;
      rx_msg        <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_complete   <= 1'b0;
    end else begin
      s1          <= rx;
      rx_s        <= s1;
      rx_complete <= 1'b0;

      if (state == IDLE || state_nxt == IDLE || at_last) cnt <= '0;
      else                                                cnt <= cnt + 1'b1;

      case (state)
        START: if (at_last) idx <= IDX_FIRST;
        DATA: begin
          if (at_sample) shift[idx] <= rx_s;
          if (at_last && idx != '0) idx <= idx - 1'b1;
        end
        PARITY: if (at_sample) par <= rx_s;
        STOP: if (at_sample) begin
          rx_msg        <= shift;
          rx_parity_err <= parity_mismatch(par, shift, parity_type);
          rx_frame_err  <= ~rx_s;
          rx_complete   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clk_3125 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic       parity_type = 1'b0;
  logic [7:0] rx_msg;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_complete;

  uart_rx #(.CLKS_PER_BIT(14), .SAMPLE_AT(6)) dut (
    .clk_3125      (clk_3125),
    .rst_n         (rst_n),
    .rx            (rx),
    .parity_type   (parity_type),
    .rx_msg        (rx_msg),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_complete   (rx_complete)
  );

  always #5 clk_3125 = ~clk_3125;

  typedef struct {
    logic [7:0] data;
    logic       ptype;
    logic       bad_par;
    logic       bad_stop;
    int         gap;
    logic [7:0] exp_msg;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] msg;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] hold_msg = 8'h00;
  int         strobes = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: observe outputs at the falling edge, score any strobe.
  task automatic tick();
    exp_t e;
    @(negedge clk_3125);
    cyc++;
    if (rx_complete) begin
      strobes++;
      chk("strobe_not_double", int'(prev_strobe), 0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rx_msg", int'(rx_msg), int'(e.msg));
        chk("rx_parity_err", int'(rx_parity_err), int'(e.perr));
        chk("rx_frame_err", int'(rx_frame_err), int'(e.ferr));
        chk("strobe_cycle", cyc, e.cyc);
        hold_msg = e.msg;
      end
    end else begin
      chk("rx_msg_hold", int'(rx_msg), int'(hold_msg));
    end
    prev_strobe = rx_complete;
  endtask

  // Drive a frame at 14 clocks/bit. abort_at > 0 stops after that many
  // cycles without scoring the frame.
  task automatic send_frame(input logic [7:0] data, input logic ptype,
                            input logic bad_par, input logic bad_stop,
                            input int gap, input int abort_at,
                            input logic [7:0] exp_msg,
                            input logic exp_perr, input logic exp_ferr);
    logic [10:0] bits;
    exp_t e;
    int n;
    bits[10]  = 1'b0;
    bits[9:2] = data;
    bits[1]   = (^data) ^ ptype ^ bad_par;
    bits[0]   = ~bad_stop;
    parity_type = ptype;
    if (abort_at == 0) begin
      e.msg = exp_msg; e.perr = exp_perr; e.ferr = exp_ferr;
      e.cyc = cyc + 150;
      sb.push_back(e);
    end
    n = 0;
    for (int b = 10; b >= 0; b--) begin
      for (int c = 0; c < 14; c++) begin
        if (abort_at != 0 && n == abort_at) return;
        rx = bits[b];
        tick();
        n++;
      end
    end
    rx = 1'b1;
    for (int g = 0; g < gap; g++) tick();
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 0,  8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{8'h3C, 1'b1, 1'b0, 1'b0, 0,  8'h3C, 1'b0, 1'b0};
    vecs[2]  = '{8'h3C, 1'b1, 1'b1, 1'b0, 0,  8'h3C, 1'b1, 1'b0};
    vecs[3]  = '{8'h81, 1'b0, 1'b0, 1'b1, 30, 8'h81, 1'b0, 1'b1};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 0,  8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 0,  8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{8'h55, 1'b0, 1'b0, 1'b0, 0,  8'h55, 1'b0, 1'b0};
    vecs[7]  = '{8'hAA, 1'b0, 1'b0, 1'b0, 0,  8'hAA, 1'b0, 1'b0};
    vecs[8]  = '{8'h01, 1'b0, 1'b0, 1'b0, 0,  8'h01, 1'b0, 1'b0};
    vecs[9]  = '{8'h80, 1'b0, 1'b0, 1'b0, 0,  8'h80, 1'b0, 1'b0};
    vecs[10] = '{8'h7E, 1'b0, 1'b0, 1'b0, 0,  8'h7E, 1'b0, 1'b0};
    vecs[11] = '{8'hC3, 1'b0, 1'b0, 1'b0, 0,  8'hC3, 1'b0, 1'b0};
    vecs[12] = '{8'h10, 1'b0, 1'b0, 1'b0, 0,  8'h10, 1'b0, 1'b0};
    vecs[13] = '{8'hE7, 1'b0, 1'b0, 1'b0, 20, 8'hE7, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) tick();
    chk("reset_rx_msg", int'(rx_msg), 0);
    chk("reset_parity_err", int'(rx_parity_err), 0);
    chk("reset_frame_err", int'(rx_frame_err), 0);
    chk("reset_complete", int'(rx_complete), 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Frame table: single frames, then ten back-to-back at 154-cycle pitch
    for (int i = 0; i < 14; i++)
      send_frame(vecs[i].data, vecs[i].ptype, vecs[i].bad_par, vecs[i].bad_stop,
                 vecs[i].gap, 0, vecs[i].exp_msg, vecs[i].exp_perr, vecs[i].exp_ferr);
    chk("table_strobes", strobes, 14);

    // Short low glitch: no strobe, message held, receiver ready again
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (200) tick();
    chk("glitch_no_strobe", strobes, 14);
    send_frame(8'h4B, 1'b0, 1'b0, 1'b0, 10, 0, 8'h4B, 1'b0, 1'b0);

    // Reset during data bit 3 of 0x5A: outputs cleared, frame dropped
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0, 14 * 4 + 7, 8'h00, 1'b0, 1'b0);
    rst_n    = 1'b0;
    rx       = 1'b1;
    hold_msg = 8'h00;
    tick();
    chk("midreset_rx_msg", int'(rx_msg), 0);
    chk("midreset_parity_err", int'(rx_parity_err), 0);
    chk("midreset_frame_err", int'(rx_frame_err), 0);
    chk("midreset_complete", int'(rx_complete), 0);
    rst_n = 1'b1;
    repeat (200) tick();
    chk("midreset_no_strobe", strobes, 15);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 0, 0, 8'h96, 1'b0, 1'b0);

    // Drain: every scored frame must have produced its strobe
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("total_strobes", strobes, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that is the receiving end of the team's `uart_tx` link: it recovers 11-bit frames (start, 8 data bits MSB-first, parity, stop) from the serial line. It runs at 14 clocks per bit on the 3.125 MHz system clock. It sits between the board-to-board serial pin and the colour-detector command/data logic. It delivers each byte with a one-cycle completion strobe plus parity-error and framing-error flags.

## Interface
- `CLKS_PER_BIT`, 14: clock cycles per bit period. Must match `uart_tx`.
- `SAMPLE_AT`, 6: bit-counter value at which the line is sampled (mid-bit).
- `clk_3125`  input  1  3.125 MHz system clock; all logic is on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `rx`  input  1  serial line, asynchronous to the block, idles high.
- `parity_type`  input  1  0 = even parity (parity bit = XOR of data), 1 = odd (parity bit = ~XOR).
- `rx_msg`  output  8  last received byte; first data bit on the wire is `rx_msg[7]`.
- `rx_parity_err`  output  1  1 = received parity bit ≠ expected, for the frame in `rx_msg`.
- `rx_frame_err`  output  1  1 = stop bit sampled low, for the frame in `rx_msg`.
- `rx_complete`  output  1  one-cycle strobe: `rx_msg` and the error flags were just updated.

## Operation
- Input sync: two flops, `rx` → `s1` → `rx_s`. Both reset to 1. The FSM sees only `rx_s`.
- State machine: IDLE, START, DATA, PARITY, STOP. A 4-bit bit counter `cnt` (0..13) and a 3-bit data index `idx` are used.
- IDLE: `cnt`=0. If `rx_s`==0 → START.
- Every non-IDLE state increments `cnt` each cycle. On `cnt`==13, `cnt` wraps to 0 and the FSM moves to the next bit.
- START: at `cnt`==SAMPLE_AT, if `rx_s`==1 the start was a glitch → IDLE with no outputs changed. Otherwise, at `cnt`==13 → DATA with `idx`=7.
- DATA: at `cnt`==SAMPLE_AT, `shift[idx]` <= `rx_s`. At `cnt`==13: if `idx`==0 → PARITY, else decrement `idx`.
- PARITY: at `cnt`==SAMPLE_AT, latch `par` <= `rx_s`. At `cnt`==13 → STOP.
- STOP, at `cnt`==SAMPLE_AT, in a single edge:
  - `rx_msg` <= `shift`
  - `rx_parity_err` <= `par` ^ (^`shift`) ^ `parity_type`
  - `rx_frame_err` <= ~`rx_s`
  - `rx_complete` <= 1
  - state → IDLE
  - The FSM leaves at mid-stop-bit so a back-to-back start bit is never missed.
- `rx_msg` is updated even when an error flag is set. The flags are overwritten every frame; they are not sticky.
- `parity_type` is sampled at the STOP update edge. It must be held stable for the whole frame.
- If the stop bit is low (break/framing error), the FSM returns to IDLE anyway. It restarts only after `rx_s` is seen low in IDLE, so a held-low line after a framing error starts a new frame immediately. This is accepted behaviour.

## Timing
- Reset (`rst_n`==0 at a rising edge), effective at that edge and mid-frame as well:
  - state IDLE, `cnt`=0, `idx`=7, `shift`=0, `par`=0, sync flops = 1
  - `rx_msg`=8'h00, `rx_parity_err`=0, `rx_frame_err`=0, `rx_complete`=0
- Define E0 as the first rising edge at which `rx` is sampled 0:
  - `rx_s`=0 after E1.
  - START is entered at E2.
  - The sample edge for frame bit n (0 = start … 10 = stop) is E(9+14n), i.e. 7 cycles into each bit.
- `rx_complete` is high for exactly the one cycle following E149. It is never high for two consecutive cycles.
- `rx_msg` and the error flags change only at E149, or at reset.
- Minimum frame pitch accepted: 148 cycles from start edge to next start edge. `uart_tx` pitch is 154 or more, so back-to-back frames are always received.
- A glitch low of up to 6 cycles that returns high before the START sample produces no strobe. The FSM is back in IDLE at E9.

## Test plan
- Byte 0xA5, even parity: wire 0,1,0,1,0,0,1,0,1, parity 0, stop 1 → at E149 `rx_msg`=A5, both errors 0, `rx_complete` one cycle.
- Byte 0x3C, `parity_type`=1: parity bit 1 → `rx_msg`=3C, no errors. Same frame with parity bit 0 → `rx_msg`=3C, `rx_parity_err`=1.
- Byte 0x81 with stop bit driven 0 → `rx_msg`=81, `rx_frame_err`=1, `rx_parity_err`=0.
- `rx` low for 4 cycles then high for 200 → `rx_complete` never asserts, `rx_msg` unchanged, FSM in IDLE at E9.
- Ten back-to-back frames at 154-cycle pitch, bytes 0x00, 0xFF, 0x55, 0xAA, 0x01, 0x80, 0x7E, 0xC3, 0x10, 0xE7, even parity → ten strobes exactly 154 cycles apart, each `rx_msg` correct, no errors.
- `rst_n` low for 1 cycle during data bit 3 of 0x5A → all outputs 0 from the next cycle, no strobe for that frame. A following clean 0x96 frame is received correctly.
